alu_issue: RTL and testbench

Two-stage pipelined issue/retire unit that sits in front of the existing 32-bit combinational ALU, acting as its initiator. It accepts decoded-register-read instructions over a valid/ready handshake, and translates opcode/funct into the ALU's 3-bit func code and operand pair. It then captures the ALU result and zero flag and presents a writeback/branch record downstream with backpressure.

---
 rtl/alu_issue_pkg.sv | 45 ++++
 rtl/alu_issue_decode.sv | 104 ++++++++++
 rtl/alu_issue.sv | 151 +++++++++++++++
 tb/tb_alu_issue.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_pkg
//  Description : Shared constants for the ALU issue/retire unit: ALU func
//                codes, MIPS opcode/funct encodings and the branch-kind enum.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_issue_pkg;

    // ALU func codes driven on alu_func
    localparam logic [2:0] c_FUNC_ADD = 3'd0;
    localparam logic [2:0] c_FUNC_SUB = 3'd1;
    localparam logic [2:0] c_FUNC_AND = 3'd2;
    localparam logic [2:0] c_FUNC_OR  = 3'd3;
    localparam logic [2:0] c_FUNC_NOR = 3'd4;
    localparam logic [2:0] c_FUNC_SLT = 3'd5;
    localparam logic [2:0] c_FUNC_LUI = 3'd6;
    localparam logic [2:0] c_FUNC_NOP = 3'd7;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_SLTI  = 6'h0A;
    localparam logic [5:0] c_OP_ANDI  = 6'h0C;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_LUI   = 6'h0F;

    // R-type funct field (instr[5:0])
    localparam logic [5:0] c_FN_ADD = 6'h20;
    localparam logic [5:0] c_FN_SUB = 6'h22;
    localparam logic [5:0] c_FN_AND = 6'h24;
    localparam logic [5:0] c_FN_OR  = 6'h25;
    localparam logic [5:0] c_FN_NOR = 6'h27;
    localparam logic [5:0] c_FN_SLT = 6'h2A;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_BEQ  = 2'd1,
        BR_BNE  = 2'd2
    } br_kind_t;

endpackage
`default_nettype wire

// File: rtl/alu_issue_decode.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_decode
//  Description : Combinational decode of a MIPS instruction word plus its
//                register operands into ALU func/operands and writeback
//                sideband. Anything not recognised decodes to NOP with zero
//                operands and the illegal flag set.
//  Ports       : i_instr, i_rs_val, i_rt_val  -> o_func, o_a, o_b, o_wr_reg,
//                o_wr_en, o_br_kind, o_illegal
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_decode
    import alu_issue_pkg::*;
#(
    parameter int SIZE = 32   // must exceed 16 (immediate extension)
) (
    input  logic [31:0]     i_instr,
    input  logic [SIZE-1:0] i_rs_val,
    input  logic [SIZE-1:0] i_rt_val,
    output logic [2:0]      o_func,
    output logic [SIZE-1:0] o_a,
    output logic [SIZE-1:0] o_b,
    output logic [4:0]      o_wr_reg,
    output logic            o_wr_en,
    output br_kind_t        o_br_kind,
    output logic            o_illegal
);

    logic [5:0]      w_opcode;
    logic [5:0]      w_funct;
    logic [4:0]      w_rt;
    logic [4:0]      w_rd;
    logic [15:0]     w_imm;
    logic [SIZE-1:0] w_imm_sext;
    logic [SIZE-1:0] w_imm_zext;

    assign w_opcode   = i_instr[31:26];
    assign w_rt       = i_instr[20:16];
    assign w_rd       = i_instr[15:11];
    assign w_funct    = i_instr[5:0];
    assign w_imm      = i_instr[15:0];
    assign w_imm_sext = {{(SIZE-16){w_imm[15]}}, w_imm};
    assign w_imm_zext = {{(SIZE-16){1'b0}}, w_imm};

    always_comb begin
        o_func    = c_FUNC_NOP;
        o_a       = '0;
        o_b       = '0;
        o_wr_reg  = '0;
        o_wr_en   = 1'b0;
        o_br_kind = BR_NONE;
        o_illegal = 1'b1;
        case (w_opcode)
            c_OP_RTYPE: begin
                o_a       = i_rs_val;
                o_b       = i_rt_val;
                o_wr_reg  = w_rd;
                o_wr_en   = 1'b1;
                o_illegal = 1'b0;
                case (w_funct)
                    c_FN_ADD: o_func = c_FUNC_ADD;
                    c_FN_SUB: o_func = c_FUNC_SUB;
                    c_FN_AND: o_func = c_FUNC_AND;
                    c_FN_OR:  o_func = c_FUNC_OR;
                    c_FN_NOR: o_func = c_FUNC_NOR;
                    c_FN_SLT: o_func = c_FUNC_SLT;
                    default: begin
                        // unknown funct: fall back to the illegal record
                        o_func    = c_FUNC_NOP;
                        o_a       = '0;
                        o_b       = '0;
                        o_wr_reg  = '0;
                        o_wr_en   = 1'b0;
                        o_illegal = 1'b1;
                    end
                endcase
            end
            c_OP_ADDI, c_OP_SLTI, c_OP_ANDI, c_OP_ORI, c_OP_LUI: begin
                o_a       = i_rs_val;
                o_wr_reg  = w_rt;
                o_wr_en   = 1'b1;
                o_illegal = 1'b0;
                case (w_opcode)
                    c_OP_ADDI: begin o_func = c_FUNC_ADD; o_b = w_imm_sext; end
                    c_OP_SLTI: begin o_func = c_FUNC_SLT; o_b = w_imm_sext; end
                    c_OP_ANDI: begin o_func = c_FUNC_AND; o_b = w_imm_zext; end
                    c_OP_ORI:  begin o_func = c_FUNC_OR;  o_b = w_imm_zext; end
                    default:   begin o_func = c_FUNC_LUI; o_b = w_imm_zext; end
                endcase
            end
            c_OP_BEQ, c_OP_BNE: begin
                // branches compare by subtraction and use the ALU zero flag
                o_func    = c_FUNC_SUB;
                o_a       = i_rs_val;
                o_b       = i_rt_val;
                o_illegal = 1'b0;
                o_br_kind = (w_opcode == c_OP_BEQ) ? BR_BEQ : BR_BNE;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue
//  Description : Two-stage issue/retire unit driving a combinational 32-bit
//                ALU. Stage 1 registers the ALU operands/func plus sideband;
//                stage 2 captures the ALU result/zero and presents a retire
//                record downstream with valid/ready backpressure.
//  Ports       : clk, rst; in_valid/in_ready/in_instr/in_rs_val/in_rt_val;
//                alu_a/alu_b/alu_func (to ALU), alu_out/alu_zero (from ALU);
//                out_valid/out_ready/out_result/out_wr_reg/out_wr_en/
//                out_branch_taken/out_illegal.
//  Options     : ALU_ISSUE_STATS_EN adds stat_retired[31:0], stat_illegal[15:0]
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [SIZE-1:0] in_rs_val,
    input  logic [SIZE-1:0] in_rt_val,
    output logic [SIZE-1:0] alu_a,
    output logic [SIZE-1:0] alu_b,
    output logic [2:0]      alu_func,
    input  logic [SIZE-1:0] alu_out,
    input  logic            alu_zero,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] out_result,
    output logic [4:0]      out_wr_reg,
    output logic            out_wr_en,
    output logic            out_branch_taken,
    output logic            out_illegal
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [31:0]     stat_retired,
    output logic [15:0]     stat_illegal
`endif
);

    logic [2:0]      w_func;
    logic [SIZE-1:0] w_a;
    logic [SIZE-1:0] w_b;
    logic [4:0]      w_wr_reg;
    logic            w_wr_en;
    br_kind_t        w_br_kind;
    logic            w_illegal;
    logic            w_s1_load;
    logic            w_s2_load;
    logic            w_taken;

    logic            r_s1_valid;
    logic [4:0]      r_s1_wr_reg;
    logic            r_s1_wr_en;
    br_kind_t        r_s1_br_kind;
    logic            r_s1_illegal;

    alu_issue_decode #(.SIZE(SIZE)) u_decode (
        .i_instr   (in_instr),
        .i_rs_val  (in_rs_val),
        .i_rt_val  (in_rt_val),
        .o_func    (w_func),
        .o_a       (w_a),
        .o_b       (w_b),
        .o_wr_reg  (w_wr_reg),
        .o_wr_en   (w_wr_en),
        .o_br_kind (w_br_kind),
        .o_illegal (w_illegal)
    );

    // s2 frees as it loads, so in_ready looks through it combinationally
    assign w_s2_load = r_s1_valid && (!out_valid || out_ready);
    assign in_ready  = !r_s1_valid || w_s2_load;
    assign w_s1_load = in_valid && in_ready;

    always_comb begin
        w_taken = 1'b0;
        case (r_s1_br_kind)
            BR_BEQ:  w_taken = alu_zero;
            BR_BNE:  w_taken = !alu_zero;
            default: w_taken = 1'b0;
        endcase
    end

    // Stage 1: issue register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_func     <= c_FUNC_NOP;
            r_s1_wr_reg  <= '0;
            r_s1_wr_en   <= 1'b0;
            r_s1_br_kind <= BR_NONE;
            r_s1_illegal <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid   <= 1'b1;
            alu_a        <= w_a;
            alu_b        <= w_b;
            alu_func     <= w_func;
            r_s1_wr_reg  <= w_wr_reg;
            r_s1_wr_en   <= w_wr_en;
            r_s1_br_kind <= w_br_kind;
            r_s1_illegal <= w_illegal;
        end else if (w_s2_load) begin
            r_s1_valid   <= 1'b0;
        end
    end

    // Stage 2: retire register; fields hold while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid        <= 1'b0;
            out_result       <= '0;
            out_wr_reg       <= '0;
            out_wr_en        <= 1'b0;
            out_branch_taken <= 1'b0;
            out_illegal      <= 1'b0;
        end else if (w_s2_load) begin
            out_valid        <= 1'b1;
            out_result       <= alu_out;
            out_wr_reg       <= r_s1_wr_reg;
            out_wr_en        <= r_s1_wr_en;
            out_branch_taken <= w_taken;
            out_illegal      <= r_s1_illegal;
        end else if (out_ready) begin
            out_valid        <= 1'b0;
        end
    end

`ifdef ALU_ISSUE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_retired <= '0;
            stat_illegal <= '0;
        end else if (out_valid && out_ready) begin
            stat_retired <= stat_retired + 32'd1;
            if (out_illegal) begin
                stat_illegal <= stat_illegal + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_issue
//  Description : Self-checking bench for alu_issue. Models the downstream ALU,
//                predicts each retire record from the instruction semantics
//                and compares retirements in order via a scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_rs_val;
    logic [31:0] in_rt_val;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_func;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_wr_reg;
    logic        out_wr_en;
    logic        out_branch_taken;
    logic        out_illegal;
`ifdef ALU_ISSUE_STATS_EN
    logic [31:0] stat_retired;
    logic [15:0] stat_illegal;
`endif

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  wr_reg;
        logic        wr_en;
        logic        taken;
        logic        illegal;
    } rec_t;

    rec_t sb[$];
    int   vectors = 0;
    int   fails   = 0;
    int   retired = 0;

    always #5 clk = ~clk;

    alu_issue #(.SIZE(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_instr         (in_instr),
        .in_rs_val        (in_rs_val),
        .in_rt_val        (in_rt_val),
        .alu_a            (alu_a),
        .alu_b            (alu_b),
        .alu_func         (alu_func),
        .alu_out          (alu_out),
        .alu_zero         (alu_zero),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_result       (out_result),
        .out_wr_reg       (out_wr_reg),
        .out_wr_en        (out_wr_en),
        .out_branch_taken (out_branch_taken),
        .out_illegal      (out_illegal)
`ifdef ALU_ISSUE_STATS_EN
        ,
        .stat_retired     (stat_retired),
        .stat_illegal     (stat_illegal)
`endif
    );

    // Combinational ALU the unit drives
    always_comb begin
        case (alu_func)
            3'd0:    alu_out = alu_a + alu_b;
            3'd1:    alu_out = alu_a - alu_b;
            3'd2:    alu_out = alu_a & alu_b;
            3'd3:    alu_out = alu_a | alu_b;
            3'd4:    alu_out = ~(alu_a | alu_b);
            3'd5:    alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            3'd6:    alu_out = {alu_b[15:0], 16'h0000};
            default: alu_out = 32'd0;
        endcase
    end
    assign alu_zero = (alu_out == 32'd0);

    function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Reference: expected retire record from instruction semantics
    function automatic rec_t expect_of(input logic [31:0] ins, input logic [31:0] rs,
                                       input logic [31:0] rt);
        rec_t        e;
        logic [31:0] sx;
        logic [31:0] zx;
        e  = '0;
        sx = {{16{ins[15]}}, ins[15:0]};
        zx = {16'h0000, ins[15:0]};
        e.illegal = 1'b0;
        case (ins[31:26])
            6'h00: begin
                e.wr_en  = 1'b1;
                e.wr_reg = ins[15:11];
                case (ins[5:0])
                    6'h20: e.result = rs + rt;
                    6'h22: e.result = rs - rt;
                    6'h24: e.result = rs & rt;
                    6'h25: e.result = rs | rt;
                    6'h27: e.result = ~(rs | rt);
                    6'h2A: e.result = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0;
                    default: begin e = '0; e.illegal = 1'b1; end
                endcase
            end
            6'h08: begin e.wr_en = 1'b1; e.wr_reg = ins[20:16]; e.result = rs + sx; end
            6'h0A: begin e.wr_en = 1'b1; e.wr_reg = ins[20:16];
                         e.result = ($signed(rs) < $signed(sx)) ? 32'd1 : 32'd0; end
            6'h0C: begin e.wr_en = 1'b1; e.wr_reg = ins[20:16]; e.result = rs & zx; end
            6'h0D: begin e.wr_en = 1'b1; e.wr_reg = ins[20:16]; e.result = rs | zx; end
            6'h0F: begin e.wr_en = 1'b1; e.wr_reg = ins[20:16]; e.result = {ins[15:0], 16'h0000}; end
            6'h04: begin e.result = rs - rt; e.taken = (rs == rt); end
            6'h05: begin e.result = rs - rt; e.taken = (rs != rt); end
            default: e.illegal = 1'b1;
        endcase
        return e;
    endfunction

    // Retire monitor: compares each handshake against the scoreboard head
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            vectors++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL retire_unexpected: got result=%h with empty scoreboard", out_result);
            end else begin
                rec_t e;
                e = sb.pop_front();
                retired++;
                if (out_result !== e.result || out_wr_en !== e.wr_en ||
                    out_branch_taken !== e.taken || out_illegal !== e.illegal ||
                    (e.wr_en && out_wr_reg !== e.wr_reg)) begin
                    fails++;
                    $display("FAIL retire_record: got res=%h reg=%0d we=%b tk=%b ill=%b, want res=%h reg=%0d we=%b tk=%b ill=%b",
                             out_result, out_wr_reg, out_wr_en, out_branch_taken, out_illegal,
                             e.result, e.wr_reg, e.wr_en, e.taken, e.illegal);
                end
            end
        end
    end

    // Present one instruction; returns #1 after the accepting edge
    task automatic send(input logic [31:0] ins, input logic [31:0] rs,
                        input logic [31:0] rt, output int waits);
        in_valid  = 1'b1;
        in_instr  = ins;
        in_rs_val = rs;
        in_rt_val = rt;
        waits     = 0;
        while (1) begin
            @(negedge clk);
            waits++;
            if (in_ready === 1'b1) begin
                sb.push_back(expect_of(ins, rs, rt));
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                break;
            end
            if (waits >= 50) begin
                vectors++;
                fails++;
                $display("FAIL send_timeout: in_ready=%b after %0d cycles, want 1", in_ready, waits);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                break;
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        vectors++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: %0d records outstanding, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_rs_val = '0; in_rt_val = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        vectors += 4;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        if (alu_func !== 3'd7 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
            fails++; $display("FAIL reset_alu: got f=%0d a=%h b=%h want 7/0/0", alu_func, alu_a, alu_b);
        end
        if (out_result !== 32'd0 || out_wr_en !== 1'b0 || out_illegal !== 1'b0 ||
            out_branch_taken !== 1'b0 || out_wr_reg !== 5'd0) begin
            fails++; $display("FAIL reset_out_fields: got res=%h we=%b want zeros", out_result, out_wr_en);
        end
    endtask

    task automatic test_add();
        int w;
        send(32'h012A4020, 32'd5, 32'd7, w);
        drain();
    endtask

    task automatic test_branch();
        int w;
        send(mk_i(6'h04, 5'd1, 5'd2, 16'h0000), 32'h1234, 32'h1234, w);
        send(mk_i(6'h04, 5'd1, 5'd2, 16'h0000), 32'h1234, 32'h1235, w);
        send(mk_i(6'h05, 5'd1, 5'd2, 16'h0000), 32'h1234, 32'h1235, w);
        send(mk_i(6'h05, 5'd1, 5'd2, 16'h0000), 32'h0042, 32'h0042, w);
        drain();
    endtask

    task automatic test_immediates();
        int w;
        send(mk_i(6'h0F, 5'd0, 5'd3, 16'hABCD), 32'hDEAD_BEEF, 32'd0, w);
        send(mk_i(6'h08, 5'd1, 5'd4, 16'hFFFF), 32'd1, 32'd0, w);
        send(mk_i(6'h0A, 5'd1, 5'd5, 16'hFFFE), 32'hFFFF_FFFD, 32'd0, w);
        send(mk_i(6'h0C, 5'd1, 5'd6, 16'hF0F0), 32'hFFFF_FFFF, 32'd0, w);
        send(mk_i(6'h0D, 5'd1, 5'd7, 16'h8001), 32'h1200_0000, 32'd0, w);
        drain();
    endtask

    task automatic test_back_to_back();
        int w;
        int n0;
        n0 = retired;
        send(mk_r(5'd1, 5'd2, 5'd9,  6'h22), 32'd3, 32'd10, w);
        vectors++;
        if (w !== 1) begin fails++; $display("FAIL b2b_first_wait: got %0d want 1", w); end
        for (int i = 0; i < 4; i++) begin
            logic [5:0] fns [4];
            fns[0] = 6'h24; fns[1] = 6'h25; fns[2] = 6'h27; fns[3] = 6'h2A;
            send(mk_r(5'd1, 5'd2, 5'(10 + i), fns[i]), $urandom, $urandom, w);
            vectors++;
            if (w !== 1) begin fails++; $display("FAIL b2b_stall: item %0d waited %0d want 1", i, w); end
        end
        drain();
        vectors++;
        if (retired - n0 !== 5) begin fails++; $display("FAIL b2b_count: got %0d want 5", retired - n0); end
    endtask

    task automatic test_backpressure();
        int          w;
        int          n0;
        logic [31:0] snap_res;
        logic [4:0]  snap_reg;
        n0 = retired;
        out_ready = 1'b0;
        send(mk_r(5'd1, 5'd2, 5'd11, 6'h20), 32'd100, 32'd1, w);
        send(mk_r(5'd1, 5'd2, 5'd12, 6'h20), 32'd200, 32'd2, w);
        in_valid  = 1'b1;
        in_instr  = mk_r(5'd1, 5'd2, 5'd13, 6'h20);
        in_rs_val = 32'd300;
        in_rt_val = 32'd3;
        snap_res  = '0;
        snap_reg  = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors += 2;
            if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready: cycle %0d got %b want 0", c, in_ready); end
            if (c == 0) begin
                snap_res = out_result;
                snap_reg = out_wr_reg;
                if (out_valid !== 1'b1 || out_result !== 32'd101 || out_wr_reg !== 5'd11) begin
                    fails++; $display("FAIL bp_head: got v=%b res=%0d reg=%0d want 1/101/11", out_valid, out_result, out_wr_reg);
                end
            end else if (out_valid !== 1'b1 || out_result !== snap_res || out_wr_reg !== snap_reg) begin
                fails++; $display("FAIL bp_stable: cycle %0d got v=%b res=%0d reg=%0d want 1/%0d/%0d",
                                  c, out_valid, out_result, out_wr_reg, snap_res, snap_reg);
            end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(mk_r(5'd1, 5'd2, 5'd13, 6'h20), 32'd300, 32'd3, w);
        send(mk_r(5'd1, 5'd2, 5'd14, 6'h20), 32'd400, 32'd4, w);
        drain();
        vectors++;
        if (retired - n0 !== 4) begin fails++; $display("FAIL bp_count: got %0d want 4", retired - n0); end
    endtask

    task automatic test_illegal();
        int w;
`ifdef ALU_ISSUE_STATS_EN
        logic [31:0] r0;
        logic [15:0] i0;
        r0 = stat_retired;
        i0 = stat_illegal;
`endif
        send({6'h3F, 26'h0ABCDEF}, 32'h5555_5555, 32'hAAAA_AAAA, w);
        vectors++;
        if (alu_func !== 3'd7 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
            fails++; $display("FAIL illegal_alu: got f=%0d a=%h b=%h want 7/0/0", alu_func, alu_a, alu_b);
        end
        send(mk_r(5'd1, 5'd2, 5'd3, 6'h21), 32'd1, 32'd2, w);
        drain();
`ifdef ALU_ISSUE_STATS_EN
        @(posedge clk);
        #1;
        vectors++;
        if (stat_retired - r0 !== 32'd2 || stat_illegal - i0 !== 16'd2) begin
            fails++; $display("FAIL stats: got ret+%0d ill+%0d want 2/2", stat_retired - r0, stat_illegal - i0);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int w;
        out_ready = 1'b0;
        send(mk_r(5'd1, 5'd2, 5'd15, 6'h20), 32'd1, 32'd1, w);
        send(mk_r(5'd1, 5'd2, 5'd16, 6'h20), 32'd2, 32'd2, w);
        vectors++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL rstmid_full: in_ready got %b want 0", in_ready); end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        vectors += 3;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin fails++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
        if (alu_func !== 3'd7) begin fails++; $display("FAIL rstmid_alu_func: got %0d want 7", alu_func); end
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_ghost: out_valid got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_branch();
        test_immediates();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
`default_nettype wire
